// File: rtl/wb_arb.sv
// wb_arb: writeback arbiter between the integer pipeline (ip) and the load/store
// pipeline (lsp). Accepts completed results over valid/ready and drives the single
// register-file write port one cycle later. Also produces the retire count, the
// 64-bit instret counter and a trace PC.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ip_wb_*  / lsp_wb_*      result, dst, pc, wb_en, valid in; ready out
//   wb_hold                  debug halt, blocks all acceptance
//   wb_rf_wen/dst/data       registered register-file write port (also forwarding value)
//   wb_retire_cnt            instructions retired last cycle (0..2)
//   wb_instret               retired-instruction counter
//   wb_trace_pc              PC of the last retired instruction
module wb_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ip_wb_dst,
   input  logic [63:0] ip_wb_result,
   input  logic [63:0] ip_wb_pc,
   input  logic        ip_wb_wb_en,
   input  logic        ip_wb_valid,
   output logic        ip_wb_ready,
   input  logic [4:0]  lsp_wb_dst,
   input  logic [63:0] lsp_wb_result,
   input  logic [63:0] lsp_wb_pc,
   input  logic        lsp_wb_wb_en,
   input  logic        lsp_wb_valid,
   output logic        lsp_wb_ready,
   input  logic        wb_hold,
   output logic        wb_rf_wen,
   output logic [4:0]  wb_rf_dst,
   output logic [63:0] wb_rf_data,
   output logic [1:0]  wb_retire_cnt,
   output logic [63:0] wb_instret,
   output logic [63:0] wb_trace_pc
);

   localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

   logic        needs_ip, needs_lsp, conflict, ip_wins;
   logic        ip_fire, lsp_fire;
   logic        ip_writes, lsp_writes;
   logic [7:0]  starve_q;
   logic        rf_wen_q;
   logic [4:0]  rf_dst_q;
   logic [63:0] rf_data_q;
   logic [1:0]  retire_q;
   logic [63:0] instret_q;
   logic [63:0] trace_pc_q;

   // Writes to x0 or with wb_en=0 retire without needing the write port.
   assign needs_ip  = ip_wb_valid & ip_wb_wb_en & (ip_wb_dst != 5'd0);
   assign needs_lsp = lsp_wb_valid & lsp_wb_wb_en & (lsp_wb_dst != 5'd0);
   assign conflict  = needs_ip & needs_lsp;
   // lsp has fixed priority until ip has lost STARVE_LIMIT conflicts in a row.
   assign ip_wins   = (starve_q >= StarveLim);

   always_comb begin
      ip_wb_ready  = 1'b0;
      lsp_wb_ready = 1'b0;
      if (rst && !wb_hold) begin
         if (conflict) begin
            ip_wb_ready  = ip_wins;
            lsp_wb_ready = !ip_wins;
         end else begin
            ip_wb_ready  = 1'b1;
            lsp_wb_ready = 1'b1;
         end
      end
   end

   assign ip_fire    = ip_wb_valid & ip_wb_ready;
   assign lsp_fire   = lsp_wb_valid & lsp_wb_ready;
   // At most one of these is set: a conflict lets only one side fire.
   assign ip_writes  = ip_fire & needs_ip;
   assign lsp_writes = lsp_fire & needs_lsp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_q   <= 8'd0;
         rf_wen_q   <= 1'b0;
         rf_dst_q   <= 5'd0;
         rf_data_q  <= 64'd0;
         retire_q   <= 2'd0;
         instret_q  <= 64'd0;
         trace_pc_q <= 64'd0;
      end else begin
         if (ip_fire) begin
            starve_q <= 8'd0;
         end else if (conflict && lsp_fire && (starve_q < StarveLim)) begin
            starve_q <= starve_q + 8'd1;
         end

         rf_wen_q <= ip_writes | lsp_writes;
         if (lsp_writes) begin
            rf_dst_q  <= lsp_wb_dst;
            rf_data_q <= lsp_wb_result;
         end else if (ip_writes) begin
            rf_dst_q  <= ip_wb_dst;
            rf_data_q <= ip_wb_result;
         end

         retire_q <= {1'b0, ip_fire} + {1'b0, lsp_fire};

         if (lsp_fire) begin
            trace_pc_q <= lsp_wb_pc;
         end else if (ip_fire) begin
            trace_pc_q <= ip_wb_pc;
         end

         // Adds last cycle's count, so instret trails the write port by one cycle.
         instret_q <= instret_q + {62'd0, retire_q};
      end
   end

   assign wb_rf_wen     = rf_wen_q;
   assign wb_rf_dst     = rf_dst_q;
   assign wb_rf_data    = rf_data_q;
   assign wb_retire_cnt = retire_q;
   assign wb_instret    = instret_q;
   assign wb_trace_pc   = trace_pc_q;

endmodule

// File: tb/tb_wb_arb.sv
module tb_wb_arb;

   logic        clk;
   logic        rst;
   logic [4:0]  ip_wb_dst;
   logic [63:0] ip_wb_result;
   logic [63:0] ip_wb_pc;
   logic        ip_wb_wb_en;
   logic        ip_wb_valid;
   logic        ip_wb_ready;
   logic [4:0]  lsp_wb_dst;
   logic [63:0] lsp_wb_result;
   logic [63:0] lsp_wb_pc;
   logic        lsp_wb_wb_en;
   logic        lsp_wb_valid;
   logic        lsp_wb_ready;
   logic        wb_hold;
   logic        wb_rf_wen;
   logic [4:0]  wb_rf_dst;
   logic [63:0] wb_rf_data;
   logic [1:0]  wb_retire_cnt;
   logic [63:0] wb_instret;
   logic [63:0] wb_trace_pc;

   int n_tests = 0;
   int n_fail  = 0;

   wb_arb #(.STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .ip_wb_dst     (ip_wb_dst),
      .ip_wb_result  (ip_wb_result),
      .ip_wb_pc      (ip_wb_pc),
      .ip_wb_wb_en   (ip_wb_wb_en),
      .ip_wb_valid   (ip_wb_valid),
      .ip_wb_ready   (ip_wb_ready),
      .lsp_wb_dst    (lsp_wb_dst),
      .lsp_wb_result (lsp_wb_result),
      .lsp_wb_pc     (lsp_wb_pc),
      .lsp_wb_wb_en  (lsp_wb_wb_en),
      .lsp_wb_valid  (lsp_wb_valid),
      .lsp_wb_ready  (lsp_wb_ready),
      .wb_hold       (wb_hold),
      .wb_rf_wen     (wb_rf_wen),
      .wb_rf_dst     (wb_rf_dst),
      .wb_rf_data    (wb_rf_data),
      .wb_retire_cnt (wb_retire_cnt),
      .wb_instret    (wb_instret),
      .wb_trace_pc   (wb_trace_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ip(input logic v, input logic [4:0] d, input logic [63:0] r,
                         input logic [63:0] pc, input logic en);
      ip_wb_valid = v; ip_wb_dst = d; ip_wb_result = r; ip_wb_pc = pc; ip_wb_wb_en = en;
   endtask

   task automatic set_lsp(input logic v, input logic [4:0] d, input logic [63:0] r,
                          input logic [63:0] pc, input logic en);
      lsp_wb_valid = v; lsp_wb_dst = d; lsp_wb_result = r; lsp_wb_pc = pc; lsp_wb_wb_en = en;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wb_hold = 1'b0;
      set_ip(1'b1, 5'd5, 64'h11, 64'h10, 1'b1);
      set_lsp(1'b1, 5'd6, 64'h22, 64'h20, 1'b1);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (ip_wb_ready !== 1'b0 || lsp_wb_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready cyc %0d: ip=%b lsp=%b want 0 0", c, ip_wb_ready,
                     lsp_wb_ready);
         end
         tick();
         n_tests++;
         if (wb_rf_wen !== 1'b0 || wb_rf_dst !== 5'd0 || wb_rf_data !== 64'd0 ||
             wb_retire_cnt !== 2'd0 || wb_trace_pc !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc %0d: wen=%b dst=%0d data=%h ret=%0d pc=%h want 0",
                     c, wb_rf_wen, wb_rf_dst, wb_rf_data, wb_retire_cnt, wb_trace_pc);
         end
         n_tests++;
         if (wb_instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_instret cyc %0d: got %h want 0", c, wb_instret);
         end
      end
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      set_lsp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      rst = 1'b1;
      #1;
      n_tests++;
      if (ip_wb_ready !== 1'b1 || lsp_wb_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: ip=%b lsp=%b want 1 1", ip_wb_ready, lsp_wb_ready);
      end
   endtask

   task automatic test_single_ip();
      set_ip(1'b1, 5'd5, 64'h1234, 64'h100, 1'b1);
      #1;
      n_tests++;
      if (ip_wb_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 1", ip_wb_ready);
      end
      tick();
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      n_tests++;
      if (wb_rf_wen !== 1'b1 || wb_rf_dst !== 5'd5 || wb_rf_data !== 64'h1234 ||
          wb_retire_cnt !== 2'd1 || wb_trace_pc !== 64'h100) begin
         n_fail++;
         $display("FAIL single_write: wen=%b dst=%0d data=%h ret=%0d pc=%h want 1 5 1234 1 100",
                  wb_rf_wen, wb_rf_dst, wb_rf_data, wb_retire_cnt, wb_trace_pc);
      end
      n_tests++;
      if (wb_instret !== 64'd0) begin
         n_fail++;
         $display("FAIL single_instret_lag: got %0d want 0", wb_instret);
      end
      tick();
      n_tests++;
      if (wb_instret !== 64'd1 || wb_rf_wen !== 1'b0 || wb_retire_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL single_instret: instret=%0d wen=%b ret=%0d want 1 0 0", wb_instret,
                  wb_rf_wen, wb_retire_cnt);
      end
   endtask

   task automatic test_dual_retire();
      set_ip(1'b1, 5'd0, 64'h55, 64'h200, 1'b1);
      set_lsp(1'b1, 5'd7, 64'hAA, 64'h300, 1'b1);
      #1;
      n_tests++;
      if (ip_wb_ready !== 1'b1 || lsp_wb_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL dual_ready: ip=%b lsp=%b want 1 1", ip_wb_ready, lsp_wb_ready);
      end
      tick();
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      set_lsp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      n_tests++;
      if (wb_rf_wen !== 1'b1 || wb_rf_dst !== 5'd7 || wb_rf_data !== 64'hAA ||
          wb_retire_cnt !== 2'd2 || wb_trace_pc !== 64'h300) begin
         n_fail++;
         $display("FAIL dual_write: wen=%b dst=%0d data=%h ret=%0d pc=%h want 1 7 aa 2 300",
                  wb_rf_wen, wb_rf_dst, wb_rf_data, wb_retire_cnt, wb_trace_pc);
      end
      tick();
      n_tests++;
      if (wb_instret !== 64'd3) begin
         n_fail++;
         $display("FAIL dual_instret: got %0d want 3", wb_instret);
      end
   endtask

   task automatic test_starvation();
      // ip wins on the 5th and 10th conflict cycles.
      logic exp_ip [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      set_ip(1'b1, 5'd3, 64'h33, 64'h400, 1'b1);
      set_lsp(1'b1, 5'd4, 64'h44, 64'h500, 1'b1);
      for (int c = 0; c < 10; c++) begin
         #1;
         n_tests++;
         if (ip_wb_ready !== exp_ip[c] || lsp_wb_ready !== !exp_ip[c]) begin
            n_fail++;
            $display("FAIL starve_ready cyc %0d: ip=%b lsp=%b want %b %b", c, ip_wb_ready,
                     lsp_wb_ready, exp_ip[c], !exp_ip[c]);
         end
         tick();
         n_tests++;
         if (wb_rf_wen !== 1'b1 || wb_rf_dst !== (exp_ip[c] ? 5'd3 : 5'd4) ||
             wb_rf_data !== (exp_ip[c] ? 64'h33 : 64'h44) ||
             wb_trace_pc !== (exp_ip[c] ? 64'h400 : 64'h500)) begin
            n_fail++;
            $display("FAIL starve_write cyc %0d: wen=%b dst=%0d data=%h pc=%h ip_win=%b", c,
                     wb_rf_wen, wb_rf_dst, wb_rf_data, wb_trace_pc, exp_ip[c]);
         end
      end
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      set_lsp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      tick();
      n_tests++;
      if (wb_instret !== 64'd13) begin
         n_fail++;
         $display("FAIL starve_instret: got %0d want 13", wb_instret);
      end
   endtask

   task automatic test_hold();
      logic       hold_v [6] = '{0, 0, 1, 1, 0, 0};
      logic [4:0] dst_v  [6] = '{10, 11, 12, 12, 12, 13};
      logic       rdy_v  [6] = '{1, 1, 0, 0, 1, 1};
      logic       wen_v  [6] = '{1, 1, 0, 0, 1, 1};
      logic [4:0] odst_v [6] = '{10, 11, 11, 11, 12, 13};
      for (int c = 0; c < 6; c++) begin
         wb_hold = hold_v[c];
         set_ip(1'b1, dst_v[c], {59'd0, dst_v[c]} + 64'h1000, 64'h600, 1'b1);
         #1;
         n_tests++;
         if (ip_wb_ready !== rdy_v[c]) begin
            n_fail++;
            $display("FAIL hold_ready cyc %0d: got %b want %b", c, ip_wb_ready, rdy_v[c]);
         end
         tick();
         n_tests++;
         if (wb_rf_wen !== wen_v[c] || wb_rf_dst !== odst_v[c] ||
             wb_rf_data !== {59'd0, odst_v[c]} + 64'h1000) begin
            n_fail++;
            $display("FAIL hold_write cyc %0d: wen=%b dst=%0d data=%h want %b %0d", c,
                     wb_rf_wen, wb_rf_dst, wb_rf_data, wen_v[c], odst_v[c]);
         end
      end
      wb_hold = 1'b0;
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      tick();
      n_tests++;
      if (wb_instret !== 64'd17) begin
         n_fail++;
         $display("FAIL hold_instret: got %0d want 17", wb_instret);
      end
   endtask

   task automatic test_instret_wrap();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
      set_ip(1'b1, 5'd0, 64'h0, 64'h700, 1'b1);
      set_lsp(1'b1, 5'd9, 64'h99, 64'h800, 1'b1);
      tick();
      release dut.instret_q;
      set_lsp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      set_ip(1'b1, 5'd8, 64'h88, 64'h900, 1'b1);
      #1;
      n_tests++;
      if (wb_retire_cnt !== 2'd2 || wb_instret !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL wrap_preload: ret=%0d instret=%h want 2 fffffffffffffffe",
                  wb_retire_cnt, wb_instret);
      end
      tick();
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      n_tests++;
      if (wb_instret !== 64'h0 || wb_retire_cnt !== 2'd1) begin
         n_fail++;
         $display("FAIL wrap_zero: instret=%h ret=%0d want 0 1", wb_instret, wb_retire_cnt);
      end
      tick();
      n_tests++;
      if (wb_instret !== 64'h1) begin
         n_fail++;
         $display("FAIL wrap_one: instret=%h want 1", wb_instret);
      end
   endtask

   initial begin
      set_ip(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      set_lsp(1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      wb_hold = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_ip();
      test_dual_retire();
      test_starvation();
      test_hold();
      test_instret_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arb.md
# wb_arb

Writeback arbiter sitting directly downstream of the integer pipeline (ip) and the load/store pipeline (lsp). It accepts completed results from both over valid/ready handshakes and drives the single register-file write port one cycle later. It also produces the retire count, the 64-bit instret counter and a trace PC. Conflicts for the write port use fixed priority to lsp, plus a starvation counter that guarantees ip forward progress.

## Interface
- STARVE_LIMIT, 4, consecutive conflict cycles ip may lose before it wins; range 0..255; 0 means ip always wins.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- ip_wb_dst  in  5  destination register from ip
- ip_wb_result  in  64  result from ip
- ip_wb_pc  in  64  PC of ip instruction
- ip_wb_wb_en  in  1  ip instruction writes rd
- ip_wb_valid  in  1  ip output valid
- ip_wb_ready  out  1  wb_arb accepts ip this cycle
- lsp_wb_dst / lsp_wb_result / lsp_wb_pc / lsp_wb_wb_en / lsp_wb_valid  in  5/64/64/1/1  same meaning as the ip fields, for lsp
- lsp_wb_ready  out  1  wb_arb accepts lsp this cycle
- wb_hold  in  1  debug halt; blocks all acceptance
- wb_rf_wen  out  1  register-file write enable (registered)
- wb_rf_dst  out  5  register-file write address (registered)
- wb_rf_data  out  64  register-file write data (registered); also the forwarding value to issue
- wb_retire_cnt  out  2  instructions retired last cycle, 0..2 (registered)
- wb_instret  out  64  retired-instruction counter
- wb_trace_pc  out  64  PC of the last retired instruction (registered)

## Operation
- needs_x = x_valid & x_wb_en & (x_dst != 0). Only sources with needs_x compete for the port; writes to x0 or with wb_en=0 retire without it.
- Readies are combinational from valids, wb_en and dst. Upstream valid must not depend on ready.
- rst=0 or wb_hold=1: ip_wb_ready = lsp_wb_ready = 0.
- Otherwise, if !(needs_ip & needs_lsp): both readies = 1.
- Conflict (needs_ip & needs_lsp):
  - ip wins if starve_cnt >= STARVE_LIMIT; otherwise lsp wins.
  - The loser's ready = 0 and the winner's ready = 1.
- x_fire = x_valid & x_ready.
- starve_cnt (8 bits):
  - Reset to 0.
  - Cleared on any cycle ip_fire=1.
  - +1 on each cycle of conflict where lsp wins, saturating at STARVE_LIMIT.
  - Otherwise holds.
- Writer selection: writer = the fired source with needs_x. At most one exists by construction.
- Registered on each edge (rst=1):
  - wb_rf_wen <= writer exists.
  - wb_rf_dst / wb_rf_data <= writer fields; both hold their previous value when there is no writer.
  - wb_retire_cnt <= ip_fire + lsp_fire.
  - wb_trace_pc <= lsp_wb_pc if lsp_fire, else ip_wb_pc if ip_fire, else hold.
  - wb_instret <= wb_instret + wb_retire_cnt, i.e. the count from the previous cycle. Wraps modulo 2^64.
- Reset values: wb_rf_wen=0, wb_rf_dst=0, wb_rf_data=0, wb_retire_cnt=0, wb_instret=0, wb_trace_pc=0, starve_cnt=0.

## Timing
- Latency: a fire in cycle N appears on wb_rf_* / wb_retire_cnt / wb_trace_pc in cycle N+1. It is reflected in wb_instret in cycle N+2.
- Throughput: one port write per cycle; up to 2 retirements per cycle.
- An unaccepted source must hold its fields stable while valid=1. wb_arb holds no input copy, so there is no skid storage.
- wb_hold asserted mid-stream: no fires in that cycle. Registered outputs from the previous cycle's fires still update; wb_rf_wen returns to 0 the following cycle. starve_cnt holds during hold.
- rst=0 mid-operation: all outputs take reset values at the next edge. Readies are 0 during reset, so no instruction is accepted or lost.
- Simultaneous ip and lsp retirement with only one writing: both fire the same cycle, and wb_retire_cnt=2 next cycle.
- instret wrap: 64'hFFFF_FFFF_FFFF_FFFF + 2 = 64'h1.

## Test plan
- Reset: hold rst=0 for 3 cycles with both valids=1 -> readies 0 throughout. All outputs 0 after the first edge; instret stays 0.
- Single ip write: ip valid, dst=5, result=64'h1234, wb_en=1, lsp idle -> ip_ready=1. Next cycle wb_rf_wen=1, dst=5, data=64'h1234, retire_cnt=1; instret=1 one cycle later.
- Dual retire, one writer: ip dst=0 wb_en=1, lsp dst=7 data=64'hAA -> both fire. Next cycle wen=1, dst=7, data=64'hAA, retire_cnt=2, trace_pc=lsp pc.
- Starvation, STARVE_LIMIT=4: both continuously write (ip dst=3, lsp dst=4) -> lsp wins 4 cycles, ip wins the 5th cycle and starve_cnt clears. The pattern repeats: 4 lsp writes, 1 ip write.
- Hold: wb_hold=1 for 2 cycles during a continuous ip stream -> ip_ready=0 both cycles. wb_rf_wen=0 on the 2nd hold cycle and the cycle after; the stream resumes with no dropped or duplicated dst.
- instret wrap: preload instret to 64'hFFFF_FFFF_FFFF_FFFE via a force, then dual-retire once and single-retire once -> wb_instret reads 64'h0, then 64'h1.
